sha256d_core: RTL and testbench

//  Double-SHA-256 engine for an 80-byte Bitcoin block header: hash(hash(header)).
//  It is one of N parallel lanes in the miner top level. All lanes share clk, rst,

---
 rtl/sha256_pkg.sv | 62 ++++++
 rtl/sha256_round.sv | 27 ++
 rtl/sha256d_core.sv | 168 ++++++++++++++++
 tb/tb_sha256d_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the double-hash lanes.
// Holds the block encodings driven by the sequencer, the initial hash value,
// the padding words, the step numbers that frame a block, and the
// round/schedule mixing functions.
package sha256_pkg;

  // Block encodings as driven by the top-level sequencer on 'block'.
  typedef enum logic [1:0] {
    BLOCK_HDR0  = 2'd0,   // header chunk 1 (bytes 0..63)
    BLOCK_HDR1  = 2'd1,   // header chunk 2 (bytes 64..79, nonce, padding)
    BLOCK_HASH2 = 2'd2,   // second hash over the first digest
    BLOCK_IDLE  = 2'd3    // no activity
  } block_e;

  // SHA-256 initial hash value, H0 in the top word.
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // Padding words: terminating 1-bit, and message lengths of 256 and 640 bits.
  localparam logic [31:0] PAD_BIT     = 32'h80000000;
  localparam logic [31:0] PAD_LEN_256 = 32'h00000100;
  localparam logic [31:0] PAD_LEN_640 = 32'h00000280;

  // Step numbers within a block (value of 'select').
  localparam logic [6:0] STEP_LAST_MSG   = 7'd15;  // last externally supplied word
  localparam logic [6:0] STEP_LAST_PUSH  = 7'd63;  // last schedule word produced
  localparam logic [6:0] STEP_LAST_ROUND = 7'd64;  // executes round 63
  localparam logic [6:0] STEP_FFWD       = 7'd65;  // feed-forward into H

  // Sigma0 of the compression function (rotr 2, 13, 22).
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // Sigma1 of the compression function (rotr 6, 11, 25).
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // sigma0 of the message schedule (rotr 7, rotr 18, shr 3).
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1 of the message schedule (rotr 17, rotr 19, shr 10).
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  // Choose: bits of y where x is set, bits of z elsewhere.
  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  // Majority of three.
  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational.
// Ports:
//   state_in   in   256  working variables {a,b,c,d,e,f,g,h}, a in bits [255:224]
//   k          in   32   round constant K[t]
//   w          in   32   schedule word W[t]
//   state_out  out  256  working variables after round t, same packing
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);

  logic [31:0] a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s;
  logic [31:0] t1_s, t2_s;

  // Unpack the working variables, form T1/T2 and shift the register file by one.
  always_comb begin
    {a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s} = state_in;
    t1_s      = h_s + big_sigma1(e_s) + ch(e_s, f_s, g_s) + k + w;
    t2_s      = big_sigma0(a_s) + maj(a_s, b_s, c_s);
    state_out = {t1_s + t2_s, a_s, b_s, c_s, d_s + t1_s, e_s, f_s, g_s};
  end

endmodule

// File: rtl/sha256d_core.sv
// Double-SHA-256 lane for an 80-byte block header: hash(hash(header)).
// The external sequencer steps 'block' and 'select'; this core follows them,
// keeps the midstate and first digest, and publishes the final digest.
// Ports:
//   clk        in   1    clock, all state on the rising edge
//   rst        in   1    asynchronous active-low reset
//   nonce_sig  in   1    1 = midstate valid, midstate register is frozen
//   block      in   2    0/1 header chunks, 2 second hash, 3 idle
//   select     in   7    step within a block, 0..65 (larger values ignored)
//   msg_in     in   32   message word W[select] for blocks 0/1, select<=15
//   K          in   32   round constant for the round executed at this edge
//   hash_out   out  256  final digest {H0..H7}, updated at block 2 / select 65
module sha256d_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         nonce_sig,
  input  logic [1:0]   block,
  input  logic [6:0]   select,
  input  logic [31:0]  msg_in,
  input  logic [31:0]  K,
  output logic [255:0] hash_out
);

  logic [255:0]       st_r;        // working variables a..h
  logic [255:0]       hreg_r;      // chaining value H0..H7 of the current block
  logic [255:0]       mid_r;       // midstate after header chunk 1
  logic [255:0]       d1_r;        // first digest
  logic [255:0]       hash_out_r;  // published final digest
  logic [15:0][31:0]  w_r;         // rolling schedule window, [15] is the newest word

  logic               is_init_s;
  logic               is_push_s;
  logic               is_round_s;
  logic               is_ffwd_s;
  logic [255:0]       init_s;
  logic [255:0]       round_s;
  logic [255:0]       ffwd_s;
  logic [31:0]        word_in_s;
  logic [31:0]        w_exp_s;
  logic [31:0]        w_new_s;

  // Decode which step actions happen on this edge; idle block and select>65 do nothing.
  always_comb begin
    is_init_s  = 1'b0;
    is_push_s  = 1'b0;
    is_round_s = 1'b0;
    is_ffwd_s  = 1'b0;
    if (block != BLOCK_IDLE) begin
      is_init_s  = (select == 7'd0);
      is_push_s  = (select <= STEP_LAST_PUSH);
      is_round_s = (select >= 7'd1) && (select <= STEP_LAST_ROUND);
      is_ffwd_s  = (select == STEP_FFWD);
    end else begin
      is_init_s  = 1'b0;
      is_push_s  = 1'b0;
      is_round_s = 1'b0;
      is_ffwd_s  = 1'b0;
    end
  end

  // Chaining value a block starts from: IV for both fresh hashes, midstate for chunk 2.
  always_comb begin
    init_s = IV;
    case (block)
      BLOCK_HDR0:  init_s = IV;
      BLOCK_HDR1:  init_s = mid_r;
      BLOCK_HASH2: init_s = IV;
      default:     init_s = IV;
    endcase
  end

  // Message word source: msg_in for header chunks, first digest plus fixed padding for the second hash.
  always_comb begin
    word_in_s = msg_in;
    if (block == BLOCK_HASH2) begin
      if (select[3] == 1'b0) begin
        // Steps 0..7 take D1 words, H0 first.
        word_in_s = d1_r[{3'd7 - select[2:0], 5'd0} +: 32];
      end else begin
        case (select[2:0])
          3'd0:    word_in_s = PAD_BIT;
          3'd7:    word_in_s = PAD_LEN_256;
          default: word_in_s = 32'd0;
        endcase
      end
    end else begin
      word_in_s = msg_in;
    end
  end

  // Next schedule word: supplied word for steps 0..15, expansion from the window afterwards.
  // Word t is captured one edge before round t executes, so the round always finds
  // W_t already registered in the newest window slot.
  always_comb begin
    w_exp_s = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
    w_new_s = w_exp_s;
    if (select <= STEP_LAST_MSG) begin
      w_new_s = word_in_s;
    end else begin
      w_new_s = w_exp_s;
    end
  end

  sha256_round u_round (
    .state_in  (st_r),
    .k         (K),
    .w         (w_r[15]),
    .state_out (round_s)
  );

  // Feed-forward sum H_i + working variable i, word by word.
  always_comb begin
    ffwd_s = 256'd0;
    for (int i = 0; i < 8; i++) begin
      ffwd_s[i*32 +: 32] = hreg_r[i*32 +: 32] + st_r[i*32 +: 32];
    end
  end

  // Working variables and chaining value: load, run rounds, fold in at the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_r   <= 256'd0;
      hreg_r <= 256'd0;
    end else if (is_init_s) begin
      st_r   <= init_s;
      hreg_r <= init_s;
    end else if (is_round_s) begin
      st_r   <= round_s;
    end else if (is_ffwd_s) begin
      hreg_r <= ffwd_s;
    end
  end

  // Schedule window: shift in one word per step from 0 to 63.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_r <= 512'd0;
    end else if (is_push_s) begin
      w_r <= {w_new_s, w_r[15:1]};
    end
  end

  // Block results: midstate (unless frozen), first digest, or the published digest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mid_r      <= 256'd0;
      d1_r       <= 256'd0;
      hash_out_r <= 256'd0;
    end else if (is_ffwd_s) begin
      case (block)
        BLOCK_HDR0: begin
          if (!nonce_sig) begin
            mid_r <= ffwd_s;
          end
        end
        BLOCK_HDR1:  d1_r       <= ffwd_s;
        BLOCK_HASH2: hash_out_r <= ffwd_s;
        default: begin
        end
      endcase
    end
  end

  assign hash_out = hash_out_r;

endmodule

// File: tb/tb_sha256d_core.sv
// Self-checking bench for sha256d_core: a reference double-SHA-256 model
// computes each expected digest when block 2 is launched; a monitor pops it
// at the block 2 / select 65 edge and otherwise checks that hash_out holds.
module tb_sha256d_core;

  logic         clk;
  logic         rst;
  logic         nonce_sig;
  logic [1:0]   block;
  logic [6:0]   select;
  logic [31:0]  msg_in;
  logic [31:0]  K;
  logic [255:0] hash_out;

  int n_total = 0;
  int n_bad   = 0;

  logic [255:0] sb_q [$];
  logic [255:0] held_m = 256'd0;
  logic [255:0] exp_m;
  logic         upd_m;

  localparam logic [255:0] M_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [639:0] GENESIS_HDR =
    640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;

  localparam logic [255:0] GENESIS_DIGEST =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256d_core dut (
    .clk       (clk),
    .rst       (rst),
    .nonce_sig (nonce_sig),
    .block     (block),
    .select    (select),
    .msg_in    (msg_in),
    .K         (K),
    .hash_out  (hash_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it does not match.
  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference single-block SHA-256 compression with a full 64-word schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] blk1_of(input logic [639:0] h);
    return {h[127:0], 32'h80000000, 320'd0, 32'h00000280};
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] h);
    logic [255:0] m;
    logic [255:0] d;
    m = compress(M_IV, h[639:128]);
    d = compress(m, blk1_of(h));
    return compress(M_IV, {d, 32'h80000000, 192'd0, 32'h00000100});
  endfunction

  // Drive steps 0..last_s of one block; off-window msg_in and K are random.
  task automatic run_block(input logic [1:0] blk, input logic [511:0] words, input int last_s);
    for (int s = 0; s <= last_s; s++) begin
      @(negedge clk);
      block  = blk;
      select = 7'(s);
      if (s <= 15 && blk != 2'd2) msg_in = words[511 - 32*s -: 32];
      else                        msg_in = $urandom;
      if (s >= 1 && s <= 64) K = k_tab[s-1];
      else                   K = $urandom;
    end
  endtask

  // Gap cycles: idle block, or active block with out-of-range select.
  task automatic idle(input int n, input logic junk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (junk) begin
        block  = 2'($urandom_range(0, 2));
        select = 7'($urandom_range(66, 127));
      end else begin
        block  = 2'd3;
        select = 7'($urandom_range(0, 127));
      end
      msg_in = $urandom;
      K      = $urandom;
    end
  endtask

  task automatic run_tail(input logic [639:0] h);
    run_block(2'd1, blk1_of(h), 65);
    idle(2, 1'b1);
    sb_q.push_back(sha256d(h));
    run_block(2'd2, 512'd0, 65);
    idle(3, 1'b0);
  endtask

  task automatic full_run(input logic [639:0] h);
    run_block(2'd0, h[639:128], 65);
    idle(2, 1'b1);
    run_tail(h);
  endtask

  // Monitor: digest check on the update edge, hold check on every other edge.
  always @(posedge clk) begin
    upd_m = rst && (block == 2'd2) && (select == 7'd65);
    #1;
    if (!rst) begin
      held_m = 256'd0;
      chk("reset_hold", hash_out, held_m);
    end else if (upd_m) begin
      chk("sb_avail", 256'(sb_q.size() != 0), 256'd1);
      if (sb_q.size() != 0) begin
        exp_m = sb_q.pop_front();
        chk("digest", hash_out, exp_m);
        held_m = exp_m;
      end
    end else begin
      chk("hold", hash_out, held_m);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want summary before limit");
    $fatal(1);
  end

  initial begin
    logic [639:0] g2;
    logic [639:0] gr;
    logic [511:0] junk_blk;
    rst       = 1'b0;
    nonce_sig = 1'b0;
    block     = 2'd3;
    select    = 7'd0;
    msg_in    = 32'd0;
    K         = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_out", hash_out, 256'd0);
    rst = 1'b1;

    // Full genesis run from scratch.
    full_run(GENESIS_HDR);
    chk("genesis_vec", hash_out, GENESIS_DIGEST);

    // Midstate reuse: 1,2,3,1,2.
    nonce_sig = 1'b1;
    run_tail(GENESIS_HDR);
    chk("reuse_first", hash_out, GENESIS_DIGEST);
    idle(4, 1'b0);
    run_tail(GENESIS_HDR);
    chk("reuse_second", hash_out, GENESIS_DIGEST);

    // Stray block 0 with other data must not disturb the frozen midstate.
    for (int i = 0; i < 16; i++) junk_blk[511 - 32*i -: 32] = $urandom;
    run_block(2'd0, junk_blk, 65);
    idle(2, 1'b1);
    run_tail(GENESIS_HDR);
    chk("midstate_locked", hash_out, GENESIS_DIGEST);

    // Nonce + 1 on the reused midstate.
    g2 = GENESIS_HDR;
    g2[31:0] = GENESIS_HDR[31:0] + 32'd1;
    run_tail(g2);
    chk("nonce_changes", 256'(hash_out != GENESIS_DIGEST), 256'd1);

    // Random headers, full runs.
    nonce_sig = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) gr[639 - 32*i -: 32] = $urandom;
      full_run(gr);
    end

    // Reset in the middle of block 1, then a clean genesis run.
    run_block(2'd0, GENESIS_HDR[639:128], 65);
    idle(1, 1'b1);
    run_block(2'd1, blk1_of(GENESIS_HDR), 30);
    @(posedge clk);
    #3;
    rst   = 1'b0;
    block = 2'd3;
    #1;
    chk("async_clear", hash_out, 256'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    full_run(GENESIS_HDR);
    chk("after_reset", hash_out, GENESIS_DIGEST);

    chk("sb_drained", 256'(sb_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
